// File: rtl/ttl_pkg.sv
// Shared definitions for the cascaded TTL counter chain.
//   CNT_UP / CNT_DN : values of the up input
//   MOD_BCD/MOD_BIN : common stage moduli (LS160 / LS163 style)
//   terminal()      : stage terminal-count test for a given direction
package ttl_pkg;
  localparam logic CNT_UP  = 1'b1;
  localparam logic CNT_DN  = 1'b0;
  localparam int   MOD_BCD = 10;
  localparam int   MOD_BIN = 16;

  // Up: terminal at MOD-1. Down: terminal at 0. Values >= MOD are never
  // terminal when counting up, so an illegal loaded value simply runs off
  // the top of the W-bit range.
  function automatic logic terminal(input int unsigned val, input logic up,
                                    input int unsigned mod);
    return (up == CNT_UP) ? (val == mod - 32'd1) : (val == 32'd0);
  endfunction
endpackage

// File: rtl/ttl_counter_chain_if.sv
// Control/data bundle of the counter chain.
//   master : drives n_sclr, n_load, p, ent, enp, up; samples q, stage_tc, rco, tc_pulse
//   slave  : the counter chain itself
interface ttl_counter_chain_if #(
  parameter int DIGITS = 2,
  parameter int W      = 4
);
  logic                  n_sclr;
  logic                  n_load;
  logic [DIGITS*W-1:0]   p;
  logic                  ent;
  logic                  enp;
  logic                  up;
  logic [DIGITS*W-1:0]   q;
  logic [DIGITS-1:0]     stage_tc;
  logic                  rco;
  logic                  tc_pulse;

  modport master (output n_sclr, n_load, p, ent, enp, up,
                  input  q, stage_tc, rco, tc_pulse);
  modport slave  (input  n_sclr, n_load, p, ent, enp, up,
                  output q, stage_tc, rco, tc_pulse);
endinterface

// File: rtl/ttl_counter_chain_stage.sv
// One counter digit: W-bit register, modulo-MOD up/down step.
//   clk, n_clr : clock, async active-low clear
//   n_sclr     : sync clear (highest edge priority)
//   load       : sync parallel load of load_val
//   cnt_en     : step enable (already includes the lower-stage enable chain)
//   up         : direction
//   q, tc      : current value, terminal flag for the current direction
module ttl_counter_stage
  import ttl_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         n_clr,
  input  logic         n_sclr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         cnt_en,
  input  logic         up,
  output logic [W-1:0] q,
  output logic         tc
);
  localparam logic [W-1:0] L_TOP = W'(MOD - 1);

  logic [W-1:0] r_q;
  logic [W-1:0] w_step;

  // Plain W-bit +/-1 outside the legal range keeps illegal values moving
  // (up walks to 2**W-1 then 0, down walks back into range).
  always_comb begin
    w_step = r_q;
    if (up == CNT_UP) w_step = (r_q == L_TOP) ? '0 : r_q + W'(1);
    else              w_step = (r_q == '0)    ? L_TOP : r_q - W'(1);
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr)       r_q <= '0;
    else if (!n_sclr) r_q <= '0;
    else if (load)    r_q <= load_val;
    else if (cnt_en)  r_q <= w_step;
  end

  assign q  = r_q;
  assign tc = terminal(32'(r_q), up, MOD);
endmodule

// File: rtl/ttl_counter_chain.sv
// Cascaded synchronous counter: DIGITS stages of W bits, each modulo MOD.
//   clk    : rising-edge clock
//   n_clr  : async active-low reset (q, tc_pulse to 0)
//   bus    : slave side of ttl_counter_chain_if (sclr/load/p/enables/up in,
//            q/stage_tc/rco/tc_pulse out)
// AUTO_RELOAD=1 turns the chain into a programmable divider: the full-chain
// terminal edge loads p instead of wrapping.
module ttl_counter_chain
  import ttl_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int W           = 4,
  parameter int MOD         = 10,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                 clk,
  input  logic                 n_clr,
  ttl_counter_chain_if.slave   bus
);
  logic [DIGITS-1:0][W-1:0] w_p;
  logic [DIGITS-1:0][W-1:0] w_q;
  logic [DIGITS-1:0]        w_tc;
  logic [DIGITS-1:0]        w_en_chain;
  logic                     w_all_tc;
  logic                     w_event;
  logic                     w_load;
  logic                     r_tc_pulse;

  assign w_p      = bus.p;
  assign w_all_tc = &w_tc;
  // Full-chain wrap actually happening at this edge (not masked by sclr/load).
  assign w_event  = bus.ent & bus.enp & w_all_tc & bus.n_sclr & bus.n_load;
  assign w_load   = ~bus.n_load | ((AUTO_RELOAD != 0) & w_event);

  for (genvar i = 0; i < DIGITS; i++) begin : g_stage
    // Stage i steps only when every lower stage sits at its terminal value.
    if (i == 0) begin : g_first
      assign w_en_chain[i] = bus.ent & bus.enp;
    end else begin : g_next
      assign w_en_chain[i] = w_en_chain[i-1] & w_tc[i-1];
    end

    ttl_counter_stage #(.W(W), .MOD(MOD)) u_stage (
      .clk      (clk),
      .n_clr    (n_clr),
      .n_sclr   (bus.n_sclr),
      .load     (w_load),
      .load_val (w_p[i]),
      .cnt_en   (w_en_chain[i]),
      .up       (bus.up),
      .q        (w_q[i]),
      .tc       (w_tc[i])
    );
  end

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) r_tc_pulse <= 1'b0;
    else        r_tc_pulse <= w_event;
  end

  assign bus.q        = w_q;
  assign bus.stage_tc = w_tc;
  assign bus.rco      = bus.ent & w_all_tc;
  assign bus.tc_pulse = r_tc_pulse;
endmodule

// File: tb/tb_ttl_counter_chain.sv
// Bench for ttl_counter_chain: three instances sharing stimulus
//   d0: BCD, 2 digits, wrap     d1: BCD, 2 digits, auto-reload
//   d2: binary, 3 digits, wrap
// Reference model treats the count as a list of decimal/hex digits and
// applies the counting rules digit by digit as ripple arithmetic.
module tb_ttl_counter_chain;
  logic clk = 1'b0;
  logic n_clr;
  always #5 clk = ~clk;

  ttl_counter_chain_if #(.DIGITS(2), .W(4)) b0 ();
  ttl_counter_chain_if #(.DIGITS(2), .W(4)) b1 ();
  ttl_counter_chain_if #(.DIGITS(3), .W(4)) b2 ();

  ttl_counter_chain #(.DIGITS(2), .W(4), .MOD(10), .AUTO_RELOAD(0)) dut0 (.clk(clk), .n_clr(n_clr), .bus(b0));
  ttl_counter_chain #(.DIGITS(2), .W(4), .MOD(10), .AUTO_RELOAD(1)) dut1 (.clk(clk), .n_clr(n_clr), .bus(b1));
  ttl_counter_chain #(.DIGITS(3), .W(4), .MOD(16), .AUTO_RELOAD(0)) dut2 (.clk(clk), .n_clr(n_clr), .bus(b2));

  int total = 0;
  int bad   = 0;

  // model state: count as packed hex digits, tc_pulse expectation
  int m0, m1, m2;
  bit t0, t1, t2;
  // currently applied inputs
  bit c_sclr, c_load, c_ent, c_enp, c_up;
  int c_p;

  function automatic int dig(int s, int i);
    return (s >> (4*i)) & 15;
  endfunction

  function automatic bit dterm(int d, int mod, bit up);
    return up ? (d == mod - 1) : (d == 0);
  endfunction

  function automatic int mstc(int s, int nd, int mod, bit up);
    int r = 0;
    for (int i = 0; i < nd; i++) if (dterm(dig(s, i), mod, up)) r |= (1 << i);
    return r;
  endfunction

  function automatic bit mall(int s, int nd, int mod, bit up);
    return mstc(s, nd, mod, up) == ((1 << nd) - 1);
  endfunction

  function automatic bit mevent(int s, int nd, int mod);
    return c_sclr && c_load && c_ent && c_enp && mall(s, nd, mod, c_up);
  endfunction

  function automatic int mnext(int s, int nd, int mod, bit ar);
    int mask = (1 << (4*nd)) - 1;
    int r = 0;
    bit carry = 1'b1;
    if (!c_sclr) return 0;
    if (!c_load) return c_p & mask;
    if (!(c_ent && c_enp)) return s;
    if (ar && mall(s, nd, mod, c_up)) return c_p & mask;
    for (int i = 0; i < nd; i++) begin
      int d = dig(s, i);
      int n = d;
      if (carry) begin
        if (c_up) n = (d == mod - 1) ? 0 : ((d + 1) & 15);
        else      n = (d == 0) ? mod - 1 : d - 1;
      end
      r |= n << (4*i);
      carry = carry && dterm(d, mod, c_up);
    end
    return r;
  endfunction

  task automatic set_in(input bit sclr, input bit load, input bit ent, input bit enp,
                        input bit up, input int p);
    logic [11:0] pv;
    pv = p[11:0];
    c_sclr = sclr; c_load = load; c_ent = ent; c_enp = enp; c_up = up; c_p = p;
    b0.n_sclr = sclr; b0.n_load = load; b0.ent = ent; b0.enp = enp; b0.up = up; b0.p = pv[7:0];
    b1.n_sclr = sclr; b1.n_load = load; b1.ent = ent; b1.enp = enp; b1.up = up; b1.p = pv[7:0];
    b2.n_sclr = sclr; b2.n_load = load; b2.ent = ent; b2.enp = enp; b2.up = up; b2.p = pv;
    #1;
  endtask

  task automatic tick();
    int n0, n1, n2;
    bit e0, e1, e2;
    n0 = mnext(m0, 2, 10, 1'b0); e0 = mevent(m0, 2, 10);
    n1 = mnext(m1, 2, 10, 1'b1); e1 = mevent(m1, 2, 10);
    n2 = mnext(m2, 3, 16, 1'b0); e2 = mevent(m2, 3, 16);
    @(posedge clk);
    #1;
    m0 = n0; m1 = n1; m2 = n2;
    t0 = e0; t1 = e1; t2 = e2;
  endtask

  task automatic test_reset();
    n_clr = 1'b0;
    set_in(1, 1, 1, 1, 1, 0);
    m0 = 0; m1 = 0; m2 = 0; t0 = 0; t1 = 0; t2 = 0;
    #11;
    total++; if (b0.q !== 8'h00) begin bad++; $display("FAIL reset_q0 got=%h want=00", b0.q); end
    total++; if (b2.q !== 12'h000) begin bad++; $display("FAIL reset_q2 got=%h want=000", b2.q); end
    total++; if ({b0.tc_pulse, b1.tc_pulse, b2.tc_pulse} !== 3'b000) begin
      bad++; $display("FAIL reset_tcp got=%b want=000", {b0.tc_pulse, b1.tc_pulse, b2.tc_pulse}); end
    n_clr = 1'b1;
  endtask

  task automatic test_count_up();
    set_in(0, 1, 1, 1, 1, 0); tick();
    set_in(1, 1, 1, 1, 1, 0);
    repeat (99) tick();
    total++; if (b0.q !== 8'h99) begin bad++; $display("FAIL up99_q got=%h want=99", b0.q); end
    total++; if (b0.rco !== 1'b1) begin bad++; $display("FAIL up99_rco got=%b want=1", b0.rco); end
    tick();
    total++; if (b0.q !== 8'h00) begin bad++; $display("FAIL upwrap_q got=%h want=00", b0.q); end
    total++; if (b0.tc_pulse !== 1'b1) begin bad++; $display("FAIL upwrap_tcp got=%b want=1", b0.tc_pulse); end
    tick();
    total++; if (b0.tc_pulse !== 1'b0) begin bad++; $display("FAIL upwrap_tcp_off got=%b want=0", b0.tc_pulse); end
    total++; if (b0.q !== 8'h01) begin bad++; $display("FAIL up_after_q got=%h want=01", b0.q); end
    total++; if (b2.q !== 12'(m2)) begin bad++; $display("FAIL up_bin_q got=%h want=%h", b2.q, 12'(m2)); end
  endtask

  task automatic test_down();
    set_in(0, 1, 1, 1, 0, 0); tick();
    set_in(1, 1, 1, 1, 0, 0);
    total++; if (b0.rco !== 1'b1) begin bad++; $display("FAIL dn00_rco got=%b want=1", b0.rco); end
    tick();
    total++; if (b0.q !== 8'h99) begin bad++; $display("FAIL dnwrap_q got=%h want=99", b0.q); end
    total++; if (b0.tc_pulse !== 1'b1) begin bad++; $display("FAIL dnwrap_tcp got=%b want=1", b0.tc_pulse); end
    set_in(0, 1, 1, 1, 0, 0); tick();
    set_in(1, 1, 1, 1, 0, 0);
    total++; if (b0.rco !== 1'b1) begin bad++; $display("FAIL dn_rco_ent1 got=%b want=1", b0.rco); end
    set_in(1, 1, 0, 1, 0, 0);
    total++; if (b0.rco !== 1'b0) begin bad++; $display("FAIL dn_rco_ent0 got=%b want=0", b0.rco); end
    // direction flip without a clock: at 00, up makes stage_tc fall
    set_in(1, 1, 0, 1, 1, 0);
    total++; if (b0.stage_tc !== 2'b00) begin bad++; $display("FAIL dir_stc got=%b want=00", b0.stage_tc); end
  endtask

  task automatic test_autoreload();
    int n;
    set_in(1, 0, 1, 1, 1, 'h95); tick();
    set_in(1, 1, 1, 1, 1, 'h95);
    repeat (4) tick();
    total++; if (b1.q !== 8'h99) begin bad++; $display("FAIL ar_top got=%h want=99", b1.q); end
    tick();
    total++; if (b1.q !== 8'h95) begin bad++; $display("FAIL ar_reload got=%h want=95", b1.q); end
    total++; if (b1.tc_pulse !== 1'b1) begin bad++; $display("FAIL ar_tcp got=%b want=1", b1.tc_pulse); end
    n = 0;
    do begin tick(); n++; end while (b1.q !== 8'h95 && n < 20);
    total++; if (n != 5) begin bad++; $display("FAIL ar_period got=%0d want=5", n); end
  endtask

  task automatic test_priority();
    set_in(1, 1, 1, 1, 1, 0); tick();
    set_in(0, 0, 1, 1, 1, 'h42); tick();
    total++; if (b0.q !== 8'h00) begin bad++; $display("FAIL prio_sclr got=%h want=00", b0.q); end
    set_in(1, 0, 0, 1, 0, 'h42); tick();
    total++; if (b0.q !== 8'h42) begin bad++; $display("FAIL prio_load got=%h want=42", b0.q); end
    total++; if (b2.q !== 12'h042) begin bad++; $display("FAIL prio_load2 got=%h want=042", b2.q); end
  endtask

  task automatic test_illegal();
    logic [7:0] seq [4];
    seq = '{8'h0D, 8'h0E, 8'h0F, 8'h00};
    set_in(1, 0, 1, 1, 1, 'h0C); tick();
    set_in(1, 1, 1, 1, 1, 'h0C);
    total++; if (b0.stage_tc[0] !== 1'b0) begin bad++; $display("FAIL ill_tc_0C got=%b want=0", b0.stage_tc[0]); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (b0.q !== seq[i]) begin bad++; $display("FAIL ill_q%0d got=%h want=%h", i, b0.q, seq[i]); end
      total++; if (b0.stage_tc[0] !== 1'b0) begin bad++; $display("FAIL ill_tc%0d got=%b want=0", i, b0.stage_tc[0]); end
    end
    set_in(1, 1, 1, 1, 0, 'h0C);
    set_in(1, 0, 1, 1, 0, 'h0C); tick();
    set_in(1, 1, 1, 1, 0, 'h0C); tick();
    total++; if (b0.q !== 8'h0B) begin bad++; $display("FAIL ill_dn got=%h want=0B", b0.q); end
  endtask

  task automatic test_async_clear();
    int n;
    set_in(1, 0, 1, 1, 1, 'h57); tick();
    set_in(1, 1, 1, 1, 1, 'h57);
    n = 0;
    do begin tick(); n++; end while (b1.tc_pulse !== 1'b1 && n < 100);
    total++; if (b1.tc_pulse !== 1'b1) begin bad++; $display("FAIL aclr_wait got=timeout want=tc_pulse"); end
    total++; if (b1.q !== 8'h57) begin bad++; $display("FAIL aclr_pre got=%h want=57", b1.q); end
    #2 n_clr = 1'b0;
    #1;
    total++; if (b1.q !== 8'h00) begin bad++; $display("FAIL aclr_q got=%h want=00", b1.q); end
    total++; if (b1.tc_pulse !== 1'b0) begin bad++; $display("FAIL aclr_tcp got=%b want=0", b1.tc_pulse); end
    m0 = 0; m1 = 0; m2 = 0; t0 = 0; t1 = 0; t2 = 0;
    #1 n_clr = 1'b1;
    tick();
    total++; if (b0.q !== 8'h01) begin bad++; $display("FAIL aclr_resume got=%h want=01", b0.q); end
  endtask

  task automatic test_bin_wrap();
    int pulses = 0;
    set_in(0, 1, 1, 1, 1, 0); tick();
    set_in(1, 1, 1, 1, 1, 0);
    repeat (4096) begin
      tick();
      if (b2.tc_pulse === 1'b1) pulses++;
    end
    total++; if (b2.q !== 12'h000) begin bad++; $display("FAIL bin_q got=%h want=000", b2.q); end
    total++; if (pulses != 1) begin bad++; $display("FAIL bin_pulses got=%0d want=1", pulses); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      set_in(($urandom % 16) != 0, ($urandom % 12) != 0, ($urandom % 8) != 0,
             ($urandom % 8) != 0, ($urandom % 4) != 0, int'($urandom & 32'hfff));
      total++; if (b0.stage_tc !== 2'(mstc(m0, 2, 10, c_up)) || b0.rco !== (c_ent && mall(m0, 2, 10, c_up))) begin
        bad++; $display("FAIL rnd_comb0 it=%0d got=%b/%b want=%b/%b", it, b0.stage_tc, b0.rco,
                        2'(mstc(m0, 2, 10, c_up)), c_ent && mall(m0, 2, 10, c_up)); end
      total++; if (b2.stage_tc !== 3'(mstc(m2, 3, 16, c_up)) || b2.rco !== (c_ent && mall(m2, 3, 16, c_up))) begin
        bad++; $display("FAIL rnd_comb2 it=%0d got=%b/%b want=%b/%b", it, b2.stage_tc, b2.rco,
                        3'(mstc(m2, 3, 16, c_up)), c_ent && mall(m2, 3, 16, c_up)); end
      tick();
      total++; if (b0.q !== 8'(m0) || b0.tc_pulse !== t0) begin
        bad++; $display("FAIL rnd_d0 it=%0d got=%h/%b want=%h/%b", it, b0.q, b0.tc_pulse, 8'(m0), t0); end
      total++; if (b1.q !== 8'(m1) || b1.tc_pulse !== t1) begin
        bad++; $display("FAIL rnd_d1 it=%0d got=%h/%b want=%h/%b", it, b1.q, b1.tc_pulse, 8'(m1), t1); end
      total++; if (b2.q !== 12'(m2) || b2.tc_pulse !== t2) begin
        bad++; $display("FAIL rnd_d2 it=%0d got=%h/%b want=%h/%b", it, b2.q, b2.tc_pulse, 12'(m2), t2); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_down();
    test_autoreload();
    test_priority();
    test_illegal();
    test_async_clear();
    test_bin_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
